// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch sequencer for the single-cycle core.
// Fetches over a req/ready handshake, waits for exec_done, then resolves the next PC.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [5:0]  alu_control,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic        branch_taken;
  logic        jump_misaligned;
  logic        unused_func;

  // func_code does not affect sequencing; only alu_op selects branches.
  assign unused_func = ^alu_control[3:0];

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign halted    = (state == HALT);

  assign seq_pc       = pc + 32'(PC_STEP);
  assign branch_taken = (alu_control[5:4] == 2'b11) && zero;

  always_comb begin
    next_pc         = seq_pc;
    jump_misaligned = 1'b0;
    if (halt) begin
      next_pc = pc;
    end else if (jump) begin
      next_pc         = {jump_target[31:2], 2'b00};
      jump_misaligned = |jump_target[1:0];
    end else if (branch_taken) begin
      next_pc = seq_pc + (branch_offset << 2);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_ready) state_nxt = EXEC;
      EXEC:    if (exec_done) state_nxt = halt ? HALT : FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= '0;
      instr_valid  <= 1'b0;
      retired      <= '0;
      misalign_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      instr_valid <= 1'b0;
      if (state == FETCH && imem_ready) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (state == EXEC && exec_done) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
        if (jump_misaligned)
          misalign_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequencing, stalls, branches, jumps, halt, reset and PC wrap.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_w;
  logic        imem_ready, exec_done, zero, jump, halt;
  logic [31:0] imem_rdata, branch_offset, jump_target;
  logic [5:0]  alu_control;

  logic        imem_req, instr_valid, halted, misalign_err;
  logic [31:0] imem_addr, instr, pc, retired;

  logic        imem_req_w, instr_valid_w, halted_w, misalign_err_w;
  logic [31:0] imem_addr_w, instr_w, pc_w, retired_w;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .alu_control(alu_control), .zero(zero),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .halt(halt), .pc(pc), .retired(retired), .halted(halted),
    .misalign_err(misalign_err)
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
    .clk(clk), .rst_n(rst_n_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ready(1'b1), .imem_rdata(32'h1234_5678),
    .instr(instr_w), .instr_valid(instr_valid_w),
    .exec_done(1'b1), .alu_control(6'b000000), .zero(1'b0),
    .branch_offset(32'h0), .jump(1'b0), .jump_target(32'h0),
    .halt(1'b0), .pc(pc_w), .retired(retired_w), .halted(halted_w),
    .misalign_err(misalign_err_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: one-cycle fetch, then exec_done with the given control inputs.
  task automatic exec_one(input logic [5:0] ctrl, input logic z, input logic [31:0] off,
                          input logic j, input logic [31:0] jt, input logic h);
    imem_ready = 1'b1;
    exec_done  = 1'b0;
    tick();
    imem_ready    = 1'b0;
    alu_control   = ctrl;
    zero          = z;
    branch_offset = off;
    jump          = j;
    jump_target   = jt;
    halt          = h;
    exec_done     = 1'b1;
    tick();
    exec_done     = 1'b0;
    alu_control   = '0;
    zero          = 1'b0;
    branch_offset = '0;
    jump          = 1'b0;
    jump_target   = '0;
    halt          = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst_n_w = 1'b0;
    imem_ready = 1'b0; exec_done = 1'b0; zero = 1'b0; jump = 1'b0; halt = 1'b0;
    imem_rdata = '0; branch_offset = '0; jump_target = '0; alu_control = '0;
    tick(); tick();

    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);

    // Three back-to-back instructions; exec_done held high, ignored in FETCH.
    rst_n = 1'b1;
    tick();
    imem_ready = 1'b1;
    exec_done  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("seq_req", {31'b0, imem_req}, 32'h1);
      check("seq_addr", imem_addr, 32'(4 * i));
      check("seq_valid_lo", {31'b0, instr_valid}, 32'h0);
      imem_rdata = 32'hA0 + 32'(i);
      tick();
      check("seq_valid_hi", {31'b0, instr_valid}, 32'h1);
      check("seq_instr", instr, 32'hA0 + 32'(i));
      tick();
    end
    check("seq_retired", retired, 32'd3);
    check("seq_pc", pc, 32'hC);

    // Stalled fetch: request and address hold, no instr_valid.
    imem_ready = 1'b0;
    exec_done  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_req", {31'b0, imem_req}, 32'h1);
      check("stall_addr", imem_addr, 32'hC);
      check("stall_valid", {31'b0, instr_valid}, 32'h0);
      tick();
    end
    imem_ready = 1'b1;
    imem_rdata = 32'hBEEF;
    tick();
    imem_ready = 1'b0;
    check("stall_valid_hi", {31'b0, instr_valid}, 32'h1);
    check("stall_instr", instr, 32'hBEEF);
    tick();
    check("stall_valid_once", {31'b0, instr_valid}, 32'h0);
    check("exec_req_lo", {31'b0, imem_req}, 32'h0);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("stall_pc", pc, 32'h10);
    check("stall_retired", retired, 32'd4);
    check("instr_hold", instr, 32'hBEEF);

    // Branches from pc=0x10.
    exec_one(6'b110001, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0);
    check("br_taken", imem_addr, 32'hC);
    exec_one(6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("br_seq", imem_addr, 32'h10);
    exec_one(6'b110001, 1'b0, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0);
    check("br_nz", imem_addr, 32'h14);
    exec_one(6'b110001, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0);
    check("br_back", imem_addr, 32'h10);
    exec_one(6'b010001, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0);
    check("br_not_op", imem_addr, 32'h14);

    // Jumps override a taken branch; misalignment is sticky.
    exec_one(6'b110001, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h103, 1'b0);
    check("jmp_pc", pc, 32'h100);
    check("jmp_misalign", {31'b0, misalign_err}, 32'h1);
    exec_one(6'b000000, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    check("jmp2_pc", pc, 32'h200);
    check("jmp2_misalign", {31'b0, misalign_err}, 32'h1);
    exec_one(6'b000000, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0);
    check("jmp3_pc", pc, 32'h8);
    check("pre_halt_retired", retired, 32'd12);

    // Halt has priority over jump and freezes pc.
    exec_one(6'b110001, 1'b1, 32'h4, 1'b1, 32'h40, 1'b1);
    check("halt_halted", {31'b0, halted}, 32'h1);
    check("halt_req", {31'b0, imem_req}, 32'h0);
    check("halt_pc", pc, 32'h8);
    check("halt_retired", retired, 32'd13);
    imem_ready = 1'b1;
    exec_done  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("halt_stuck_pc", pc, 32'h8);
      check("halt_stuck_ret", retired, 32'd13);
      check("halt_stuck_req", {31'b0, imem_req}, 32'h0);
      check("halt_stuck_valid", {31'b0, instr_valid}, 32'h0);
    end
    imem_ready = 1'b0;
    exec_done  = 1'b0;

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rerst_pc", pc, 32'h0);
    check("rerst_halted", {31'b0, halted}, 32'h0);
    check("rerst_misalign", {31'b0, misalign_err}, 32'h0);
    check("rerst_retired", retired, 32'h0);
    check("rerst_idle_req", {31'b0, imem_req}, 32'h0);
    tick();
    check("rerst_fetch_req", {31'b0, imem_req}, 32'h1);
    check("rerst_fetch_addr", imem_addr, 32'h0);

    // Reset while a fetch would complete.
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst_n      = 1'b0;
    tick();
    rst_n      = 1'b1;
    imem_ready = 1'b0;
    check("abort_instr", instr, 32'h0);
    check("abort_valid", {31'b0, instr_valid}, 32'h0);
    check("abort_retired", retired, 32'h0);
    tick();
    check("abort_valid2", {31'b0, instr_valid}, 32'h0);
    check("abort_req", {31'b0, imem_req}, 32'h1);

    // Sequential step from the top of the address space wraps to zero.
    rst_n_w = 1'b1;
    tick();
    check("wrap_addr0", imem_addr_w, 32'hFFFF_FFFC);
    check("wrap_req", {31'b0, imem_req_w}, 32'h1);
    tick();
    tick();
    check("wrap_addr1", imem_addr_w, 32'h0);
    check("wrap_retired", retired_w, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
